axi_lsu_master: RTL and testbench

Single-outstanding AXI4 master that turns the core's load/store request port into single-beat AXI4 read or write transactions toward the crossbar and its slaves (CLINT, SRAM, UART). It issues AR/R or AW/W/B handshakes, checks the response, and returns the read data and an error flag to the LSU. It is the initiator counterpart of the team's AXI4 slave peripherals.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_lsu_master.sv | 182 ++++++++++++++++++
 tb/tb_axi_lsu_master.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the LSU master state type.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RSP
    } lsu_state_e;

endpackage

// File: rtl/axi_lsu_master.sv
// Single-outstanding AXI4 master turning LSU load/store requests into
// single-beat AR/R or AW/W/B transactions.
//
// state   | meaning
// IDLE    | waiting for an LSU request (req_ready high)
// RD_ADDR | ARVALID held until ARREADY
// RD_DATA | RREADY high, waiting for RVALID
// WR_REQ  | AWVALID/WVALID held, each dropping on its own handshake
// WR_RESP | BREADY high, waiting for BVALID
// RSP     | one-cycle rsp_valid pulse back to the LSU
module axi_lsu_master
    import axi_pkg::*;
#(
    parameter logic [3:0] ID = 4'h0
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    output logic [3:0]  M_AXI_ARID,
    output logic [7:0]  M_AXI_ARLEN,
    output logic [2:0]  M_AXI_ARSIZE,
    output logic [1:0]  M_AXI_ARBURST,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    input  logic        M_AXI_RLAST,
    input  logic [3:0]  M_AXI_RID,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [3:0]  M_AXI_AWID,
    output logic [7:0]  M_AXI_AWLEN,
    output logic [2:0]  M_AXI_AWSIZE,
    output logic [1:0]  M_AXI_AWBURST,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    output logic        M_AXI_WLAST,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    input  logic [3:0]  M_AXI_BID
);

    lsu_state_e state;
    logic       aw_done;
    logic       w_done;
    logic       aw_hs;
    logic       w_hs;
    logic       unused;

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] a);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return a[0];
            SIZE_W:  return a != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    assign req_ready     = (state == IDLE) && S_AXI_ARESETN;
    assign M_AXI_ARID    = ID;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_AWID    = ID;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_RREADY  = (state == RD_DATA);
    assign M_AXI_BREADY  = (state == WR_RESP);
    assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs          = M_AXI_WVALID && M_AXI_WREADY;
    // Single-beat reads make RLAST redundant; only the error bit of a response matters.
    assign unused        = ^{M_AXI_RLAST, M_AXI_RRESP[0], M_AXI_BRESP[0]};

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state         <= IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARSIZE  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWSIZE  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        if (misaligned(req_size, req_addr[1:0])) begin
                            rsp_err <= 1'b1;
                            state   <= RSP;
                        end else if (req_we) begin
                            M_AXI_AWADDR  <= req_addr;
                            M_AXI_AWSIZE  <= req_size;
                            M_AXI_WDATA   <= req_wdata;
                            M_AXI_WSTRB   <= req_wstrb;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= WR_REQ;
                        end else begin
                            M_AXI_ARADDR  <= req_addr;
                            M_AXI_ARSIZE  <= req_size;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        rsp_rdata <= M_AXI_RDATA;
                        rsp_err   <= M_AXI_RRESP[1] | (M_AXI_RID != ID);
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs))
                        state <= WR_RESP;
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        rsp_rdata <= '0;
                        rsp_err   <= M_AXI_BRESP[1] | (M_AXI_BID != ID);
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    // Misaligned requests arrive with the pulse not yet raised.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lsu_master.sv
// Randomized bench for axi_lsu_master with a configurable AXI slave and a word-level memory model.
module tb_axi_lsu_master;

    logic        S_AXI_ACLK;
    logic        S_AXI_ARESETN;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] M_AXI_ARADDR, M_AXI_RDATA, M_AXI_AWADDR, M_AXI_WDATA;
    logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY, M_AXI_RLAST;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WLAST, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic [3:0]  M_AXI_ARID, M_AXI_RID, M_AXI_AWID, M_AXI_WSTRB, M_AXI_BID;
    logic [7:0]  M_AXI_ARLEN, M_AXI_AWLEN;
    logic [2:0]  M_AXI_ARSIZE, M_AXI_AWSIZE;
    logic [1:0]  M_AXI_ARBURST, M_AXI_AWBURST, M_AXI_RRESP, M_AXI_BRESP;

    axi_lsu_master #(.ID(4'h0)) dut (
        .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
        .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RID(M_AXI_RID),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
        .M_AXI_AWBURST(M_AXI_AWBURST),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_BID(M_AXI_BID)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    initial S_AXI_ACLK = 1'b0;
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;
    always @(posedge S_AXI_ACLK) cyc <= cyc + 1;

    // Slave knobs, set by each test before issuing a request
    int         cfg_ar_delay = 0, cfg_r_delay = 0, cfg_aw_delay = 0, cfg_w_delay = 0, cfg_b_delay = 0;
    bit         cfg_r_never = 0;
    logic [1:0] cfg_rresp = 2'b00, cfg_bresp = 2'b00;
    logic [3:0] cfg_rid = 4'h0, cfg_bid = 4'h0;

    // Slave-side records
    int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
    bit          r_pending, r_fire, b_pending, b_fire, aw_ok, w_ok;
    int          ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0;
    int          aw_hs_cyc, w_hs_cyc;
    logic [31:0] rec_araddr, rec_awaddr, rec_wdata;
    logic [2:0]  rec_arsize, rec_awsize;
    logic [7:0]  rec_arlen;
    logic [1:0]  rec_arburst;
    logic [3:0]  rec_arid, rec_wstrb;
    logic        rec_wlast;
    bit          log_arvalid [0:1023];
    bit          log_awvalid [0:1023];
    bit          log_wvalid  [0:1023];
    bit          log_bready  [0:1023];

    logic [31:0] slave_mem [bit [29:0]];
    logic [31:0] model_mem [bit [29:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hA5C3_0F17;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (ws[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // AXI slave: decides READY/VALID on the falling edge, so every handshake it grants lands on the next rising edge
    always @(negedge S_AXI_ACLK) begin
        log_arvalid[cyc % 1024] = M_AXI_ARVALID;
        log_awvalid[cyc % 1024] = M_AXI_AWVALID;
        log_wvalid[cyc % 1024]  = M_AXI_WVALID;
        log_bready[cyc % 1024]  = M_AXI_BREADY;
        if (!S_AXI_ARESETN) begin
            M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
            ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
            r_pending = 0; r_fire = 0; b_pending = 0; b_fire = 0; aw_ok = 0; w_ok = 0;
        end else begin
            if (r_fire) begin M_AXI_RVALID = 0; r_fire = 0; end
            if (r_pending && !M_AXI_RVALID) begin
                if (!cfg_r_never && r_wait >= cfg_r_delay) begin
                    M_AXI_RVALID = 1;
                    M_AXI_RDATA  = slave_mem.exists(rec_araddr[31:2]) ? slave_mem[rec_araddr[31:2]]
                                                                      : init_word(rec_araddr);
                    M_AXI_RRESP  = cfg_rresp;
                    M_AXI_RID    = cfg_rid;
                end else r_wait++;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin r_fire = 1; r_pending = 0; end

            M_AXI_ARREADY = 0;
            if (M_AXI_ARVALID) begin
                if (ar_wait >= cfg_ar_delay) begin
                    M_AXI_ARREADY = 1; ar_hs_n++; ar_wait = 0;
                    rec_araddr = M_AXI_ARADDR; rec_arsize = M_AXI_ARSIZE; rec_arlen = M_AXI_ARLEN;
                    rec_arburst = M_AXI_ARBURST; rec_arid = M_AXI_ARID;
                    r_pending = 1; r_wait = 0;
                end else ar_wait++;
            end

            if (b_fire) begin M_AXI_BVALID = 0; b_fire = 0; end
            if (b_pending && !M_AXI_BVALID) begin
                if (b_wait >= cfg_b_delay) begin
                    M_AXI_BVALID = 1; M_AXI_BRESP = cfg_bresp; M_AXI_BID = cfg_bid;
                end else b_wait++;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin b_fire = 1; b_pending = 0; end

            M_AXI_AWREADY = 0;
            if (M_AXI_AWVALID) begin
                if (aw_wait >= cfg_aw_delay) begin
                    M_AXI_AWREADY = 1; aw_hs_n++; aw_wait = 0; aw_ok = 1; aw_hs_cyc = cyc;
                    rec_awaddr = M_AXI_AWADDR; rec_awsize = M_AXI_AWSIZE;
                end else aw_wait++;
            end
            M_AXI_WREADY = 0;
            if (M_AXI_WVALID) begin
                if (w_wait >= cfg_w_delay) begin
                    M_AXI_WREADY = 1; w_hs_n++; w_wait = 0; w_ok = 1; w_hs_cyc = cyc;
                    rec_wdata = M_AXI_WDATA; rec_wstrb = M_AXI_WSTRB; rec_wlast = M_AXI_WLAST;
                end else w_wait++;
            end
            if (aw_ok && w_ok) begin
                slave_mem[rec_awaddr[31:2]] = merge(slave_mem.exists(rec_awaddr[31:2]) ?
                    slave_mem[rec_awaddr[31:2]] : init_word(rec_awaddr), rec_wdata, rec_wstrb);
                aw_ok = 0; w_ok = 0; b_pending = 1; b_wait = 0;
            end
        end
    end

    // Drives one request and waits for its response; lat is -1 if no response arrives in time
    task automatic do_request(input bit we, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wd, input logic [3:0] ws,
                              output int lat, output logic [31:0] rd, output logic er,
                              output int n_ar, output int n_aw, output int n_w,
                              output int acc, output bit pulse_ok);
        int ar0, aw0, w0, k;
        ar0 = ar_hs_n; aw0 = aw_hs_n; w0 = w_hs_n;
        lat = -1; rd = 'x; er = 1'bx; pulse_ok = 0;
        @(negedge S_AXI_ACLK);
        req_we = we; req_addr = addr; req_size = size; req_wdata = wd; req_wstrb = ws; req_valid = 1;
        k = 0;
        while (!req_ready && k < 100) begin @(negedge S_AXI_ACLK); k++; end
        acc = cyc;
        @(negedge S_AXI_ACLK);
        req_valid = 0;
        k = 0;
        while (!rsp_valid && k < 200) begin @(negedge S_AXI_ACLK); k++; end
        if (rsp_valid) begin
            lat = cyc - acc; rd = rsp_rdata; er = rsp_err;
            @(negedge S_AXI_ACLK);
            pulse_ok = !rsp_valid && req_ready;
        end
        n_ar = ar_hs_n - ar0; n_aw = aw_hs_n - aw0; n_w = w_hs_n - w0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a[31:2]) ? model_mem[a[31:2]] : init_word(a);
    endfunction

    task automatic test_reset();
        S_AXI_ARESETN = 0;
        repeat (3) @(negedge S_AXI_ACLK);
        tests++;
        if ({M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY, M_AXI_BREADY, req_ready, rsp_valid, rsp_err} !== 8'h00) begin
            fails++; $display("FAIL reset_ctrl got %b want 00000000",
                {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY, M_AXI_BREADY, req_ready, rsp_valid, rsp_err});
        end
        tests++;
        if ({M_AXI_ARADDR, M_AXI_AWADDR, M_AXI_WDATA, rsp_rdata} !== 128'h0) begin
            fails++; $display("FAIL reset_data got %h %h %h %h want 0", M_AXI_ARADDR, M_AXI_AWADDR, M_AXI_WDATA, rsp_rdata);
        end
        S_AXI_ARESETN = 1;
        @(negedge S_AXI_ACLK);
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready); end
    endtask

    task automatic test_clint_load();
        int lat, n_ar, n_aw, n_w, acc; logic [31:0] rd; logic er; bit pok;
        slave_mem[30'h0080_0000] = 32'h0000_0010;
        model_mem[30'h0080_0000] = 32'h0000_0010;
        cfg_ar_delay = 1; cfg_r_delay = 1; cfg_rresp = 2'b00; cfg_rid = 4'h0;
        do_request(0, 32'h0200_0000, 3'd2, 32'h0, 4'h0, lat, rd, er, n_ar, n_aw, n_w, acc, pok);
        tests++; if (lat !== 5) begin fails++; $display("FAIL clint_latency got %0d want 5", lat); end
        tests++; if (rd !== 32'h10) begin fails++; $display("FAIL clint_rdata got %h want 00000010", rd); end
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL clint_err got %b want 0", er); end
        tests++; if (n_ar !== 1) begin fails++; $display("FAIL clint_ar_count got %0d want 1", n_ar); end
        tests++;
        if ({rec_arlen, rec_arsize, rec_arburst, rec_arid} !== {8'd0, 3'd2, 2'b01, 4'h0}) begin
            fails++; $display("FAIL clint_ar_fields got len %h size %0d burst %b id %h want 00 2 01 0",
                rec_arlen, rec_arsize, rec_arburst, rec_arid);
        end
        tests++; if (!pok) begin fails++; $display("FAIL clint_pulse got not-one-cycle want one-cycle"); end
    endtask

    task automatic test_store();
        int lat, n_ar, n_aw, n_w, acc; logic [31:0] rd; logic er; bit pok;
        cfg_aw_delay = 0; cfg_w_delay = 0; cfg_b_delay = 0; cfg_bresp = 2'b01; cfg_bid = 4'h0;
        do_request(1, 32'h8000_0004, 3'd2, 32'hDEAD_BEEF, 4'hF, lat, rd, er, n_ar, n_aw, n_w, acc, pok);
        model_mem[30'h2000_0001] = 32'hDEAD_BEEF;
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL store_err got %b want 0", er); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL store_rdata got %h want 0", rd); end
        tests++;
        if ({log_awvalid[(acc + 1) % 1024], log_wvalid[(acc + 1) % 1024], log_awvalid[acc % 1024], log_wvalid[acc % 1024]} !== 4'b1100) begin
            fails++; $display("FAIL store_rise_together got aw %b w %b want aw/w rise on same cycle",
                log_awvalid[(acc + 1) % 1024], log_wvalid[(acc + 1) % 1024]);
        end
        tests++; if (rec_wlast !== 1'b1) begin fails++; $display("FAIL store_wlast got %b want 1", rec_wlast); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL store_latency got %0d want 3", lat); end
        cfg_ar_delay = 0; cfg_r_delay = 0; cfg_rresp = 2'b00; cfg_rid = 4'h0;
        do_request(0, 32'h8000_0004, 3'd2, 32'h0, 4'h0, lat, rd, er, n_ar, n_aw, n_w, acc, pok);
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL store_readback got %h want deadbeef", rd); end
    endtask

    task automatic test_w_before_aw();
        int lat, n_ar, n_aw, n_w, acc; logic [31:0] rd; logic er; bit pok; bit early;
        cfg_aw_delay = 3; cfg_w_delay = 0; cfg_b_delay = 0; cfg_bresp = 2'b00; cfg_bid = 4'h0;
        do_request(1, 32'h8000_0020, 3'd2, 32'h1234_5678, 4'h3, lat, rd, er, n_ar, n_aw, n_w, acc, pok);
        tests++;
        if (log_wvalid[(acc + 2) % 1024] !== 1'b0 || log_awvalid[(acc + 2) % 1024] !== 1'b1) begin
            fails++; $display("FAIL wfirst_valids got w %b aw %b want w 0 aw 1",
                log_wvalid[(acc + 2) % 1024], log_awvalid[(acc + 2) % 1024]);
        end
        early = 0;
        for (int c = 1; c <= 4; c++) if (log_bready[(acc + c) % 1024]) early = 1;
        tests++; if (early) begin fails++; $display("FAIL wfirst_bready got early BREADY want none before both handshakes"); end
        tests++;
        if (w_hs_cyc - acc !== 1 || aw_hs_cyc - acc !== 4) begin
            fails++; $display("FAIL wfirst_hs_cycles got w %0d aw %0d want w 1 aw 4", w_hs_cyc - acc, aw_hs_cyc - acc);
        end
        tests++; if (n_aw !== 1 || n_w !== 1) begin fails++; $display("FAIL wfirst_counts got aw %0d w %0d want 1 1", n_aw, n_w); end
        tests++; if (lat !== 6 || !pok) begin fails++; $display("FAIL wfirst_response got lat %0d pulse %b want 6 1", lat, pok); end
        model_mem[30'h2000_0008] = merge(model_read(32'h8000_0020), 32'h1234_5678, 4'h3);
    endtask

    task automatic test_misaligned();
        int lat, n_ar, n_aw, n_w, acc; logic [31:0] rd; logic er; bit pok; bit seen;
        do_request(0, 32'h8000_0002, 3'd2, 32'h0, 4'h0, lat, rd, er, n_ar, n_aw, n_w, acc, pok);
        seen = 0;
        for (int c = 0; c <= 3; c++) if (log_arvalid[(acc + c) % 1024]) seen = 1;
        tests++; if (seen || n_ar !== 0) begin fails++; $display("FAIL misal_arvalid got arvalid seen %b count %0d want none", seen, n_ar); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL misal_latency got %0d want 2", lat); end
        tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL misal_rsp got err %b rdata %h want 1 0", er, rd); end
    endtask

    task automatic test_errors();
        int lat, n_ar, n_aw, n_w, acc; logic [31:0] rd; logic er; bit pok;
        cfg_ar_delay = 0; cfg_r_delay = 0; cfg_rresp = 2'b10; cfg_rid = 4'h0;
        do_request(0, 32'h1000_0000, 3'd2, 32'h0, 4'h0, lat, rd, er, n_ar, n_aw, n_w, acc, pok);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL err_rresp got %b want 1", er); end
        cfg_rresp = 2'b00; cfg_rid = 4'h3;
        do_request(0, 32'h1000_0000, 3'd2, 32'h0, 4'h0, lat, rd, er, n_ar, n_aw, n_w, acc, pok);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL err_rid got %b want 1", er); end
        cfg_rid = 4'h0; cfg_rresp = 2'b01;
        do_request(0, 32'h1000_0000, 3'd2, 32'h0, 4'h0, lat, rd, er, n_ar, n_aw, n_w, acc, pok);
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL err_exokay got %b want 0", er); end
        cfg_rresp = 2'b00;
    endtask

    task automatic test_reset_mid();
        int k;
        cfg_ar_delay = 0; cfg_r_never = 1;
        @(negedge S_AXI_ACLK);
        req_we = 0; req_addr = 32'h8000_0000; req_size = 3'd2; req_valid = 1;
        @(negedge S_AXI_ACLK);
        req_valid = 0;
        k = 0;
        while (!M_AXI_RREADY && k < 20) begin @(negedge S_AXI_ACLK); k++; end
        tests++; if (!M_AXI_RREADY) begin fails++; $display("FAIL rstmid_reach_rd_data got rready 0 want 1"); end
        S_AXI_ARESETN = 0;
        @(negedge S_AXI_ACLK);
        tests++;
        if ({M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY, M_AXI_BREADY, rsp_valid, req_ready} !== 7'b0) begin
            fails++; $display("FAIL rstmid_outputs got %b want 0000000",
                {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY, M_AXI_BREADY, rsp_valid, req_ready});
        end
        S_AXI_ARESETN = 1;
        #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %b want 1", req_ready); end
        cfg_r_never = 0;
        @(negedge S_AXI_ACLK);
    endtask

    task automatic test_random();
        int lat, n_ar, n_aw, n_w, acc, exp_lat; logic [31:0] rd, addr, wd, exp_rd; logic er, exp_er;
        logic [2:0] size; logic [3:0] ws; bit we, mis, pok;
        logic [31:0] bases [4] = '{32'h0200_0000, 32'h8000_0000, 32'h8000_0010, 32'h1000_0000};
        for (int i = 0; i < 40; i++) begin
            we   = $urandom_range(0, 1);
            addr = bases[$urandom_range(0, 3)] + $urandom_range(0, 7);
            size = ($urandom_range(0, 9) > 8) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 2) != 0 && size <= 3'd2) addr = addr & ~((32'd1 << size) - 32'd1);
            wd = $urandom; ws = 4'($urandom_range(0, 15));
            cfg_ar_delay = $urandom_range(0, 3); cfg_r_delay = $urandom_range(0, 3);
            cfg_aw_delay = $urandom_range(0, 3); cfg_w_delay = $urandom_range(0, 3); cfg_b_delay = $urandom_range(0, 3);
            cfg_rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            cfg_bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            cfg_rid = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            cfg_bid = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;

            mis = (size > 3'd2) || ((addr % (32'd1 << size)) != 0);
            if (mis) begin
                exp_er = 1; exp_rd = 0; exp_lat = 2;
            end else if (we) begin
                exp_er = (cfg_bresp >= 2'd2) || (cfg_bid != 4'h0); exp_rd = 0;
                exp_lat = 3 + ((cfg_aw_delay > cfg_w_delay) ? cfg_aw_delay : cfg_w_delay) + cfg_b_delay;
            end else begin
                exp_er = (cfg_rresp >= 2'd2) || (cfg_rid != 4'h0); exp_rd = model_read(addr);
                exp_lat = 3 + cfg_ar_delay + cfg_r_delay;
            end

            do_request(we, addr, size, wd, ws, lat, rd, er, n_ar, n_aw, n_w, acc, pok);
            if (!mis && we) model_mem[addr[31:2]] = merge(model_read(addr), wd, ws);

            tests++; if (rd !== exp_rd) begin fails++; $display("FAIL rand%0d_rdata got %h want %h", i, rd, exp_rd); end
            tests++; if (er !== exp_er) begin fails++; $display("FAIL rand%0d_err got %b want %b", i, er, exp_er); end
            tests++; if (lat !== exp_lat) begin fails++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, exp_lat); end
            tests++;
            if (n_ar !== int'(!mis && !we) || n_aw !== int'(!mis && we) || n_w !== int'(!mis && we)) begin
                fails++; $display("FAIL rand%0d_hs_counts got ar %0d aw %0d w %0d want %0d %0d %0d", i, n_ar, n_aw, n_w,
                    int'(!mis && !we), int'(!mis && we), int'(!mis && we));
            end
            tests++; if (!pok) begin fails++; $display("FAIL rand%0d_pulse got not-one-cycle want one-cycle", i); end
            if (!mis && !we) begin
                tests++;
                if (rec_araddr !== addr || rec_arsize !== size) begin
                    fails++; $display("FAIL rand%0d_ar_payload got %h/%0d want %h/%0d", i, rec_araddr, rec_arsize, addr, size);
                end
            end
            if (!mis && we) begin
                tests++;
                if (rec_awaddr !== addr || rec_awsize !== size || rec_wdata !== wd || rec_wstrb !== ws) begin
                    fails++; $display("FAIL rand%0d_w_payload got %h/%0d/%h/%h want %h/%0d/%h/%h", i,
                        rec_awaddr, rec_awsize, rec_wdata, rec_wstrb, addr, size, wd, ws);
                end
            end
        end
    endtask

    initial begin
        req_valid = 0; req_we = 0; req_addr = 0; req_size = 0; req_wdata = 0; req_wstrb = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0; M_AXI_RLAST = 1; M_AXI_RID = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_BID = 0;
        S_AXI_ARESETN = 0;
        test_reset();
        test_clint_load();
        test_store();
        test_w_before_aw();
        test_misaligned();
        test_errors();
        test_reset_mid();
        test_clint_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 50000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
